pipe_ex_collector: RTL and testbench

- Downstream stage of the 4-operand arithmetic pipeline `pipe_ex`. It consumes the pipeline's result bus F.
- It re-aligns a per-sample valid tag with the fixed pipeline latency. Each tagged result goes into a small FIFO, and results leave through a valid/ready handshake.
- It also keeps running statistics: accumulated sum, result count and dropped-result count. These let the result stream be checked at system level.

---
 rtl/pipe_ex_collector.sv | 159 +++++++++++++++
 tb/tb_pipe_ex_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ex_collector.sv
// ---------------------------------------------------------------------------
// pipe_ex_collector
//
// Sits downstream of the 4-operand arithmetic pipeline pipe_ex. The valid tag
// for each operand set is delayed by the pipeline latency so that it lines up
// with the matching result on f_in. Tagged results are written into a small
// FIFO and leave through a valid/ready handshake. Running statistics (sum of
// accepted results, accepted count and dropped count) support system-level
// checking of the result stream.
//
// Parameters
//   N      data width of f_in / out_data
//   LAT    pipeline latency from operands applied to F valid (>= 1)
//   DEPTH  FIFO entries (power of 2, >= 2)
//   ACC_W  accumulator width (>= N)
//
// Ports
//   clk        rising-edge clock shared with the pipeline
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented to the pipeline this cycle
//   f_in       pipeline result bus F
//   out_data   FIFO head entry (don't-care while out_valid is low)
//   out_valid  FIFO not empty
//   out_ready  consumer accepts out_data
//   level      FIFO occupancy
//   full       level == DEPTH
//   empty      level == 0
//   overflow   sticky: at least one result was dropped
//   drop_cnt   dropped results, saturating at 255
//   res_cnt    accepted results, saturating at 65535
//   acc_sum    wrapping sum of accepted results
// ---------------------------------------------------------------------------
module pipe_ex_collector #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [N-1:0]             f_in,
  output logic [N-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [15:0]              res_cnt,
  output logic [ACC_W-1:0]         acc_sum
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Saturating increments for the statistics counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Tag delay line: vld_p[k] is the in_valid seen k+1 cycles ago, so the
  // last stage lines up with the result the pipeline produces for it.
  logic [LAT-1:0] vld_p;
  logic           av;

  logic [N-1:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  lvl_q;

  logic           push;
  logic           pop;
  logic           drop;

  // Status flags come only from the registered occupancy, so nothing on the
  // input side or out_ready reaches them combinationally.
  assign level     = lvl_q;
  assign full      = (lvl_q == LW'(DEPTH));
  assign empty     = (lvl_q == '0);
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];

  assign av = vld_p[LAT-1];

  // A full FIFO can still accept a result in a cycle where the head leaves.
  always_comb begin
    pop  = out_valid & out_ready;
    push = av & (~full | pop);
    drop = av & full & ~pop;
  end

  // ---- stage: tag alignment ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // ---- stage: FIFO storage (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= f_in;
    end
  end

  // ---- stage: FIFO control ----
  // Pointers are exactly PW bits wide; DEPTH is a power of two, so the
  // natural binary overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // ---- stage: statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      res_cnt  <= '0;
      acc_sum  <= '0;
    end else begin
      if (push) begin
        acc_sum <= acc_sum + ACC_W'(f_in);
        res_cnt <= sat_inc16(res_cnt);
      end
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ex_collector.sv
module tb_pipe_ex_collector;

  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  f_in = '0;
  logic          out_ready = 1'b0;

  logic [N-1:0]  out_data,  out_data_b;
  logic          out_valid, out_valid_b;
  logic [2:0]    level,     level_b;
  logic          full,      full_b;
  logic          empty,     empty_b;
  logic          overflow,  overflow_b;
  logic [7:0]    drop_cnt,  drop_cnt_b;
  logic [15:0]   res_cnt,   res_cnt_b;
  logic [15:0]   acc_sum;
  logic [11:0]   acc_sum_b;

  always #5 clk = ~clk;

  pipe_ex_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .f_in(f_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .drop_cnt(drop_cnt), .res_cnt(res_cnt), .acc_sum(acc_sum)
  );

  // Second instance with a narrow accumulator, driven by the same stimulus.
  pipe_ex_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .ACC_W(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .f_in(f_in),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .level(level_b), .full(full_b), .empty(empty_b), .overflow(overflow_b),
    .drop_cnt(drop_cnt_b), .res_cnt(res_cnt_b), .acc_sum(acc_sum_b)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state
  logic [N-1:0]  sb [$];
  int            m_acc, m_res, m_drop, m_ovf;
  logic [LAT-1:0] mtag;
  logic [N-1:0]  fline [LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("level",     32'(level),     32'(sb.size()));
    chk("full",      32'(full),      32'(sb.size() == DEPTH));
    chk("empty",     32'(empty),     32'(sb.size() == 0));
    if (sb.size() != 0) chk("out_data", 32'(out_data), 32'(sb[0]));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    chk("res_cnt",   32'(res_cnt),   32'(m_res));
    chk("acc_sum",   32'(acc_sum),   32'(m_acc % 65536));
    chk("acc_sum_b", 32'(acc_sum_b), 32'(m_acc % 4096));
    chk("level_b",   32'(level_b),   32'(sb.size()));
  endtask

  // One clock cycle: entered and left at a falling edge. f_in carries the
  // value offered LAT steps earlier, mimicking the upstream pipeline; when
  // nothing was offered it carries random junk that must never be stored.
  task automatic step(input logic iv, input logic [N-1:0] v, input logic rdy);
    logic         av;
    logic [N-1:0] fa;
    logic         is_full, pop, push, drop;
    fa = fline[LAT-1];
    av = mtag[LAT-1];
    in_valid  = iv;
    f_in      = fa;
    out_ready = rdy;
    check_state();
    is_full = (sb.size() == DEPTH);
    pop  = rdy && (sb.size() != 0);
    push = av && (!is_full || pop);
    drop = av && is_full && !pop;
    if (pop) void'(sb.pop_front());
    if (push) begin
      sb.push_back(fa);
      m_acc = (m_acc + int'(fa)) % 65536;
      if (m_res < 65535) m_res++;
    end
    if (drop) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    for (int i = LAT - 1; i > 0; i--) begin
      fline[i] = fline[i-1];
      mtag[i]  = mtag[i-1];
    end
    fline[0] = iv ? v : N'($urandom);
    mtag[0]  = iv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    sb.delete();
    m_acc = 0; m_res = 0; m_drop = 0; m_ovf = 0;
    mtag = '0;
  endtask

  // Reset asserted at a falling edge, held across one rising edge.
  task automatic rst_pulse();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_state();
    @(posedge clk);
    @(negedge clk);
    check_state();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) fline[i] = '0;
    clear_model();
    @(negedge clk);
    rst_pulse();

    // Single sample
    step(1'b1, 10'd123, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'd123);
    step(1'b0, '0, 1'b1);
    chk("single_empty", 32'(empty),   32'd1);
    chk("single_res",   32'(res_cnt), 32'd1);
    chk("single_acc",   32'(acc_sum), 32'd123);

    // Fill and overflow
    rst_pulse();
    for (int i = 1; i <= 6; i++) step(1'b1, N'(i), 1'b0);
    for (int i = 0; i < LAT; i++) step(1'b0, '0, 1'b0);
    chk("fill_full",  32'(full),     32'd1);
    chk("fill_level", 32'(level),    32'd4);
    chk("fill_drop",  32'(drop_cnt), 32'd2);
    chk("fill_ovf",   32'(overflow), 32'd1);
    chk("fill_res",   32'(res_cnt),  32'd4);
    chk("fill_acc",   32'(acc_sum),  32'd10);

    // Drain
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data", 32'(out_data), 32'(k));
      step(1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(empty),    32'd1);
    chk("drain_level", 32'(level),    32'd0);
    chk("drain_ovf",   32'(overflow), 32'd1);

    // Push and pop while full
    rst_pulse();
    for (int i = 1; i <= 4; i++) step(1'b1, N'(i), 1'b0);
    step(1'b1, 10'd9, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("pp_full_before", 32'(full), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("pp_level", 32'(level),    32'd4);
    chk("pp_drop",  32'(drop_cnt), 32'd0);
    chk("pp_head",  32'(out_data), 32'd2);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    chk("pp_empty", 32'(empty), 32'd1);
    chk("pp_res",   32'(res_cnt), 32'd5);

    // Accumulator wrap on the 12-bit instance
    rst_pulse();
    for (int i = 0; i < 5; i++) step(1'b1, 10'd1000, 1'b1);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, '0, 1'b1);
    chk("wrap_acc12", 32'(acc_sum_b), 32'd904);
    chk("wrap_res12", 32'(res_cnt_b), 32'd5);
    chk("wrap_acc16", 32'(acc_sum),   32'd5000);

    // Reset mid-operation: 11,22 queued, 33,44 still in flight
    rst_pulse();
    step(1'b1, 10'd11, 1'b0);
    step(1'b1, 10'd22, 1'b0);
    step(1'b1, 10'd33, 1'b0);
    step(1'b1, 10'd44, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("mid_level", 32'(level), 32'd2);
    rst_pulse();
    chk("mid_rst_empty", 32'(empty),     32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_acc",   32'(acc_sum),   32'd0);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, '0, 1'b1);
    chk("mid_flush_empty", 32'(empty),   32'd1);
    chk("mid_flush_res",   32'(res_cnt), 32'd0);
    step(1'b1, 10'd123, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("mid_single_data", 32'(out_data), 32'd123);
    step(1'b0, '0, 1'b1);
    chk("mid_single_empty", 32'(empty),   32'd1);
    chk("mid_single_acc",   32'(acc_sum), 32'd123);

    // Drop counter saturation
    rst_pulse();
    for (int i = 0; i < 262; i++) step(1'b1, N'(i + 1), 1'b0);
    for (int i = 0; i < LAT; i++) step(1'b0, '0, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_res",  32'(res_cnt),  32'd4);
    chk("sat_acc",  32'(acc_sum),  32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
